req_pending_latch: RTL

- Upstream stage of the 16-input priority encoder.
- Synchronises 16 asynchronous request lines and turns rising edges into sticky pending bits.
- Presents the masked pending vector as the encoder's 16-bit input.
- Clears a pending bit when the downstream consumer returns the encoded index it has served. Overrun is flagged when an edge arrives on a bit that is already pending.

---
 rtl/priority_pkg.sv | 13 +
 rtl/sync_chain.sv | 25 ++
 rtl/req_pending_latch.sv | 119 +++++++++++
 3 files changed

// File: rtl/priority_pkg.sv
// rtl/priority_pkg.sv - shared constants and helpers for the 16-input priority encoder path
package priority_pkg;

    localparam int PE_WIDTH = 16;
    localparam int PE_CODE_W = 8;
    localparam logic [PE_CODE_W-1:0] PE_CODE_NONE = 8'hF0;

    // A code selects a line only when it addresses one of the encoder inputs.
    function automatic logic code_valid(input logic [PE_CODE_W-1:0] code);
        return (code < PE_CODE_W'(PE_WIDTH));
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for a bus of independent async lines
module sync_chain #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift every line one stage deeper each cycle; the last stage is the usable copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/req_pending_latch.sv
// rtl/req_pending_latch.sv - sticky pending/overrun capture in front of the priority encoder
module req_pending_latch
    import priority_pkg::*;
#(
    parameter int WIDTH       = PE_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req_in,
    input  logic [WIDTH-1:0]     mask_in,
    input  logic                 clr_valid,
    input  logic [PE_CODE_W-1:0] clr_code,
    input  logic                 ovr_clr,
    output logic [WIDTH-1:0]     pend_out,
    output logic                 pend_any,
    output logic [WIDTH-1:0]     overrun,
    output logic                 armed
);

    // Warm-up lasts until the synchroniser and history register hold real samples.
    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr_hit;
    logic [WIDTH-1:0] ovr_set;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] ovr;
    logic [CNT_W-1:0] warm_cnt;

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (WIDTH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req_in),
        .q     (s)
    );

    // Previous-cycle copy of the synchronised lines for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
        end else begin
            h <= s;
        end
    end

    // Count up after reset release and park at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= '0;
        end else if (warm_cnt != WARM_MAX) begin
            warm_cnt <= warm_cnt + CNT_W'(1);
        end
    end

    assign armed = (warm_cnt == WARM_MAX);

    // Events are suppressed during warm-up so lines held through reset never fire.
    always_comb begin
        ev = '0;
        if (armed) begin
            if (EDGE_MODE != 0) begin
                ev = s & ~h;
            end else begin
                ev = s;
            end
        end
    end

    // One-hot clear from the served code; out-of-range codes (including "none") select nothing.
    always_comb begin
        clr_hit = '0;
        if (clr_valid && code_valid(clr_code)) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (clr_code == PE_CODE_W'(i)) begin
                    clr_hit[i] = 1'b1;
                end
            end
        end
    end

    // An edge on an already pending line that is not being served is an overrun; level mode never overruns.
    always_comb begin
        ovr_set = '0;
        if (EDGE_MODE != 0) begin
            ovr_set = ev & pend & ~clr_hit;
        end
    end

    // Set beats clear so a coincident new request is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= ev | (pend & ~clr_hit);
        end
    end

    // Sticky overrun flags; a fresh overrun survives a simultaneous bulk clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr <= '0;
        end else begin
            ovr <= ovr_set | (ovr & ~{WIDTH{ovr_clr}});
        end
    end

    assign pend_out = pend & mask_in;
    assign pend_any = |pend_out;
    assign overrun  = ovr;

endmodule
